// File: rtl/base_pkg.sv
// base_pkg: definitions shared by the base_* building blocks.
//
// Contents:
//   clog2            ceiling log2, for elaboration-time widths
//   delta_width      width of the signed count + incs - decs sum
//   BASE_CMEM_ERR_*  bit positions of overflow/underflow within o_err
package base_pkg;

    localparam int BASE_CMEM_ERR_OVF = 0;
    localparam int BASE_CMEM_ERR_UNF = 1;

    // Smallest r such that 2**r >= value. Returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // The per-entry sum needs the count bits, enough bits for the
    // larger hit popcount, and a sign bit so an underflow shows up as
    // a negative value instead of wrapping.
    function automatic int delta_width(input int c_width,
                                       input int inc_ports,
                                       input int dec_ports);
        int m;
        m = (inc_ports > dec_ports) ? inc_ports : dec_ports;
        return c_width + clog2(m + 1) + 1;
    endfunction

endpackage

// File: rtl/base_cmem_ent.sv
// base_cmem_ent: one reference-count entry of base_cmem.
//
// Applies this cycle's increment and decrement hits to the count as a
// signed sum, saturates to [0, max], and lets a clear hit override
// everything. Overflow/underflow flags are combinational and describe
// the update being applied at the next rising edge; they are only
// generated when BASE_CMEM_ERR_EN is defined and are 0 otherwise.
//
// Ports:
//   clk      in   1           clock
//   reset    in   1           asynchronous, active-low
//   inc_hit  in   inc_ports   one bit per increment port hitting this entry
//   dec_hit  in   dec_ports   one bit per decrement port hitting this entry
//   clr_hit  in   1           some clear port hits this entry
//   cnt      out  c_width     current count
//   ovf      out  1           this update saturates at max
//   unf      out  1           this update saturates at 0
module base_cmem_ent
    import base_pkg::*;
#(
    parameter int c_width   = 4,
    parameter int inc_ports = 1,
    parameter int dec_ports = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [inc_ports-1:0] inc_hit,
    input  logic [dec_ports-1:0] dec_hit,
    input  logic                 clr_hit,
    output logic [c_width-1:0]   cnt,
    output logic                 ovf,
    output logic                 unf
);

    localparam int DW = delta_width(c_width, inc_ports, dec_ports);
    localparam logic [DW-1:0] MAXV = DW'((2**c_width) - 1);

    logic [DW-1:0]      ni;
    logic [DW-1:0]      nd;
    logic [DW-1:0]      sum;
    logic               sat_hi;
    logic               sat_lo;
    logic [c_width-1:0] nxt;

    // Duplicate hits from several ports count individually, so the hit
    // vectors are popcounted rather than OR-reduced.
    always_comb begin
        ni = '0;
        for (int i = 0; i < inc_ports; i++) begin
            ni = ni + DW'(inc_hit[i]);
        end
        nd = '0;
        for (int i = 0; i < dec_ports; i++) begin
            nd = nd + DW'(dec_hit[i]);
        end
        sum    = DW'(cnt) + ni - nd;
        sat_hi = $signed(sum) > $signed(MAXV);
        sat_lo = sum[DW-1];
        if (clr_hit) begin
            nxt = '0;
        end else if (sat_hi) begin
            nxt = MAXV[c_width-1:0];
        end else if (sat_lo) begin
            nxt = '0;
        end else begin
            nxt = sum[c_width-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

    // A clear wins silently: no error for an entry being cleared.
`ifdef BASE_CMEM_ERR_EN
    assign ovf = sat_hi & ~clr_hit;
    assign unf = sat_lo & ~clr_hit;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: rtl/base_decode.sv
// base_decode: address-to-one-hot decoder with a valid qualifier.
//
// Ports:
//   a    in   a_width       address
//   v    in   1             valid; all outputs are 0 when low
//   hit  out  2**a_width    one-hot hit vector, bit index = address
module base_decode
    import base_pkg::*;
#(
    parameter int a_width = 2
) (
    input  logic [a_width-1:0]      a,
    input  logic                    v,
    output logic [2**a_width-1:0]   hit
);

    always_comb begin
        hit = '0;
        if (v) begin
            hit[a] = 1'b1;
        end
    end

endmodule

// File: rtl/base_emux.sv
// base_emux: selects one width-bit element out of a flat vector.
//
// Ports:
//   d    in   width*2**s_width   elements, element k at bits [k*width +: width]
//   sel  in   s_width            element index
//   q    out  width              selected element
module base_emux
    import base_pkg::*;
#(
    parameter int width   = 4,
    parameter int s_width = 2
) (
    input  logic [width*(2**s_width)-1:0] d,
    input  logic [s_width-1:0]            sel,
    output logic [width-1:0]              q
);

    assign q = d[sel*width +: width];

endmodule

// File: rtl/base_cmem.sv
// base_cmem: per-entry counted-valid memory.
//
// Holds a c_width-bit reference count per entry (depth = 2**a_width).
// Increment, decrement and clear ports update counts every cycle with
// saturation; clear has priority. Registered read ports return the
// count and its nonzero status; a registered finder reports the
// lowest-index entry whose count is 0.
//
// For every multi-port vector (addresses, valids, enables, read data)
// port 0 occupies the most significant slice.
//
// Optional feature: define BASE_CMEM_ERR_EN to build the overflow /
// underflow detection and the o_err register. Without it o_err is 0;
// saturation still happens.
//
// Ports:
//   clk       in   1                   clock
//   reset     in   1                   asynchronous, active-low
//   i_inc_a   in   a_width*inc_ports   increment addresses
//   i_inc_v   in   inc_ports           increment valids
//   i_dec_a   in   a_width*dec_ports   decrement addresses
//   i_dec_v   in   dec_ports           decrement valids
//   i_clr_a   in   a_width*clr_ports   clear addresses
//   i_clr_v   in   clr_ports           clear valids
//   i_rd_a    in   a_width*rports      read addresses
//   i_rd_en   in   rports              read enables
//   o_rd_v    out  rports              addressed count is nonzero
//   o_rd_c    out  c_width*rports      addressed count
//   o_free_v  out  1                   some entry has count 0
//   o_free_a  out  a_width             lowest-index zero-count entry
//   o_err     out  2                   bit 0 overflow, bit 1 underflow
module base_cmem
    import base_pkg::*;
#(
    parameter int a_width   = 2,
    parameter int c_width   = 4,
    parameter int inc_ports = 1,
    parameter int dec_ports = 1,
    parameter int clr_ports = 1,
    parameter int rports    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [a_width*inc_ports-1:0] i_inc_a,
    input  logic [inc_ports-1:0]         i_inc_v,
    input  logic [a_width*dec_ports-1:0] i_dec_a,
    input  logic [dec_ports-1:0]         i_dec_v,
    input  logic [a_width*clr_ports-1:0] i_clr_a,
    input  logic [clr_ports-1:0]         i_clr_v,
    input  logic [a_width*rports-1:0]    i_rd_a,
    input  logic [rports-1:0]            i_rd_en,
    output logic [rports-1:0]            o_rd_v,
    output logic [c_width*rports-1:0]    o_rd_c,
    output logic                         o_free_v,
    output logic [a_width-1:0]           o_free_a,
    output logic [1:0]                   o_err
);

    localparam int depth = 2**a_width;

    logic [depth-1:0]         inc_oh [inc_ports];
    logic [depth-1:0]         dec_oh [dec_ports];
    logic [depth-1:0]         clr_oh [clr_ports];
    logic [c_width*depth-1:0] cnt_flat;
    logic [depth-1:0]         ovf_e;
    logic [depth-1:0]         unf_e;
    logic [depth-1:0]         zero_e;
    logic [c_width-1:0]       rd_mux [rports];
    logic                     free_any;
    logic [a_width-1:0]       free_idx;

    for (genvar p = 0; p < inc_ports; p++) begin : g_inc_dec
        base_decode #(.a_width(a_width)) u_dec (
            .a   (i_inc_a[(inc_ports-1-p)*a_width +: a_width]),
            .v   (i_inc_v[inc_ports-1-p]),
            .hit (inc_oh[p])
        );
    end

    for (genvar p = 0; p < dec_ports; p++) begin : g_dec_dec
        base_decode #(.a_width(a_width)) u_dec (
            .a   (i_dec_a[(dec_ports-1-p)*a_width +: a_width]),
            .v   (i_dec_v[dec_ports-1-p]),
            .hit (dec_oh[p])
        );
    end

    for (genvar p = 0; p < clr_ports; p++) begin : g_clr_dec
        base_decode #(.a_width(a_width)) u_dec (
            .a   (i_clr_a[(clr_ports-1-p)*a_width +: a_width]),
            .v   (i_clr_v[clr_ports-1-p]),
            .hit (clr_oh[p])
        );
    end

    for (genvar e = 0; e < depth; e++) begin : g_ent
        logic [inc_ports-1:0] ih;
        logic [dec_ports-1:0] dh;
        logic                 ch;

        // Transpose the per-port one-hot vectors into per-entry hit bits.
        always_comb begin
            ih = '0;
            for (int p = 0; p < inc_ports; p++) begin
                ih[p] = inc_oh[p][e];
            end
            dh = '0;
            for (int p = 0; p < dec_ports; p++) begin
                dh[p] = dec_oh[p][e];
            end
            ch = 1'b0;
            for (int p = 0; p < clr_ports; p++) begin
                ch = ch | clr_oh[p][e];
            end
        end

        base_cmem_ent #(
            .c_width   (c_width),
            .inc_ports (inc_ports),
            .dec_ports (dec_ports)
        ) u_ent (
            .clk     (clk),
            .reset   (reset),
            .inc_hit (ih),
            .dec_hit (dh),
            .clr_hit (ch),
            .cnt     (cnt_flat[e*c_width +: c_width]),
            .ovf     (ovf_e[e]),
            .unf     (unf_e[e])
        );

        assign zero_e[e] = (cnt_flat[e*c_width +: c_width] == '0);
    end

    for (genvar r = 0; r < rports; r++) begin : g_rd_mux
        base_emux #(.width(c_width), .s_width(a_width)) u_mux (
            .d   (cnt_flat),
            .sel (i_rd_a[(rports-1-r)*a_width +: a_width]),
            .q   (rd_mux[r])
        );
    end

    // Reads sample the count register directly, so a read in the same
    // cycle as an update sees the pre-update value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_rd_v <= '0;
            o_rd_c <= '0;
        end else begin
            for (int r = 0; r < rports; r++) begin
                if (i_rd_en[rports-1-r]) begin
                    o_rd_c[(rports-1-r)*c_width +: c_width] <= rd_mux[r];
                    o_rd_v[rports-1-r]                      <= |rd_mux[r];
                end
            end
        end
    end

    // Scanning downward leaves the lowest zero-count index in free_idx.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int e = depth - 1; e >= 0; e--) begin
            if (zero_e[e]) begin
                free_any = 1'b1;
                free_idx = a_width'(e);
            end
        end
    end

    // The address holds its last value while nothing is free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_free_v <= 1'b0;
            o_free_a <= '0;
        end else begin
            o_free_v <= free_any;
            if (free_any) begin
                o_free_a <= free_idx;
            end
        end
    end

`ifdef BASE_CMEM_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_err <= '0;
        end else begin
            o_err[BASE_CMEM_ERR_OVF] <= |ovf_e;
            o_err[BASE_CMEM_ERR_UNF] <= |unf_e;
        end
    end
`else
    // The entry flags are constant 0 in this build; fold them into a
    // deliberately unused net so they are not flagged as dangling.
    logic err_unused;
    assign err_unused = |{ovf_e, unf_e};
    assign o_err      = 2'b00;
`endif

endmodule

// File: tb/tb_base_cmem.sv
// tb_base_cmem: self-checking bench for base_cmem.
//
// The reference model keeps one integer count per entry and applies the
// counting rules with plain arithmetic at each rising edge. Directed
// sequences reproduce the documented scenarios; a randomized phase
// follows, including a reset in the middle of traffic. o_err is expected
// only when BASE_CMEM_ERR_EN is defined.
module tb_base_cmem;

    localparam int AW    = 2;
    localparam int CW    = 4;
    localparam int NI    = 2;
    localparam int ND    = 2;
    localparam int NC    = 1;
    localparam int NR    = 2;
    localparam int DEPTH = 4;
    localparam int MAXC  = 15;
`ifdef BASE_CMEM_ERR_EN
    localparam int ERRON = 1;
`else
    localparam int ERRON = 0;
`endif

    logic              clk;
    logic              reset;
    logic [AW*NI-1:0]  i_inc_a;
    logic [NI-1:0]     i_inc_v;
    logic [AW*ND-1:0]  i_dec_a;
    logic [ND-1:0]     i_dec_v;
    logic [AW*NC-1:0]  i_clr_a;
    logic [NC-1:0]     i_clr_v;
    logic [AW*NR-1:0]  i_rd_a;
    logic [NR-1:0]     i_rd_en;
    logic [NR-1:0]     o_rd_v;
    logic [CW*NR-1:0]  o_rd_c;
    logic              o_free_v;
    logic [AW-1:0]     o_free_a;
    logic [1:0]        o_err;

    base_cmem #(
        .a_width   (AW),
        .c_width   (CW),
        .inc_ports (NI),
        .dec_ports (ND),
        .clr_ports (NC),
        .rports    (NR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_inc_a  (i_inc_a),
        .i_inc_v  (i_inc_v),
        .i_dec_a  (i_dec_a),
        .i_dec_v  (i_dec_v),
        .i_clr_a  (i_clr_a),
        .i_clr_v  (i_clr_v),
        .i_rd_a   (i_rd_a),
        .i_rd_en  (i_rd_en),
        .o_rd_v   (o_rd_v),
        .o_rd_c   (o_rd_c),
        .o_free_v (o_free_v),
        .o_free_a (o_free_a),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Per-port stimulus, port 0 first.
    int s_inc_a [NI];
    bit s_inc_v [NI];
    int s_dec_a [ND];
    bit s_dec_v [ND];
    int s_clr_a [NC];
    bit s_clr_v [NC];
    int s_rd_a  [NR];
    bit s_rd_en [NR];

    // Reference model state.
    int m_cnt  [DEPTH];
    int m_rd_c [NR];
    int m_rd_v [NR];
    int m_free_v;
    int m_free_a;
    int m_err;

    task automatic checkOutput(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < NI; p++) begin s_inc_a[p] = 0; s_inc_v[p] = 0; end
        for (int p = 0; p < ND; p++) begin s_dec_a[p] = 0; s_dec_v[p] = 0; end
        for (int p = 0; p < NC; p++) begin s_clr_a[p] = 0; s_clr_v[p] = 0; end
        for (int r = 0; r < NR; r++) begin s_rd_a[r] = 0; s_rd_en[r] = 0; end
    endtask

    // Pack per-port stimulus into the DUT vectors, port 0 in the MSBs.
    task automatic applyStimulus();
        for (int p = 0; p < NI; p++) begin
            i_inc_a[(NI-1-p)*AW +: AW] = AW'(s_inc_a[p]);
            i_inc_v[NI-1-p]            = s_inc_v[p];
        end
        for (int p = 0; p < ND; p++) begin
            i_dec_a[(ND-1-p)*AW +: AW] = AW'(s_dec_a[p]);
            i_dec_v[ND-1-p]            = s_dec_v[p];
        end
        for (int p = 0; p < NC; p++) begin
            i_clr_a[(NC-1-p)*AW +: AW] = AW'(s_clr_a[p]);
            i_clr_v[NC-1-p]            = s_clr_v[p];
        end
        for (int r = 0; r < NR; r++) begin
            i_rd_a[(NR-1-r)*AW +: AW] = AW'(s_rd_a[r]);
            i_rd_en[NR-1-r]           = s_rd_en[r];
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < DEPTH; e++) m_cnt[e] = 0;
        for (int r = 0; r < NR; r++) begin m_rd_c[r] = 0; m_rd_v[r] = 0; end
        m_free_v = 0;
        m_free_a = 0;
        m_err    = 0;
    endtask

    // One rising edge: outputs are computed from the counts as they were
    // before the edge, then the counts take their new values.
    task automatic model_edge();
        int nxt [DEPTH];
        int s;
        bit cl;
        bit found;
        int ovf;
        int unf;
        for (int r = 0; r < NR; r++) begin
            if (s_rd_en[r]) begin
                m_rd_c[r] = m_cnt[s_rd_a[r]];
                m_rd_v[r] = (m_cnt[s_rd_a[r]] != 0) ? 1 : 0;
            end
        end
        found = 0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!found && m_cnt[e] == 0) begin
                found    = 1;
                m_free_a = e;
            end
        end
        m_free_v = found ? 1 : 0;
        ovf = 0;
        unf = 0;
        for (int e = 0; e < DEPTH; e++) begin
            s  = m_cnt[e];
            cl = 0;
            for (int p = 0; p < NC; p++) if (s_clr_v[p] && s_clr_a[p] == e) cl = 1;
            for (int p = 0; p < NI; p++) if (s_inc_v[p] && s_inc_a[p] == e) s = s + 1;
            for (int p = 0; p < ND; p++) if (s_dec_v[p] && s_dec_a[p] == e) s = s - 1;
            if (cl)             nxt[e] = 0;
            else if (s > MAXC) begin nxt[e] = MAXC; ovf = 1; end
            else if (s < 0)    begin nxt[e] = 0;    unf = 1; end
            else                nxt[e] = s;
        end
        m_err = (ERRON != 0) ? (unf * 2 + ovf) : 0;
        for (int e = 0; e < DEPTH; e++) m_cnt[e] = nxt[e];
    endtask

    task automatic check_all();
        for (int r = 0; r < NR; r++) begin
            checkOutput($sformatf("rd_c%0d", r), int'(o_rd_c[(NR-1-r)*CW +: CW]), m_rd_c[r]);
            checkOutput($sformatf("rd_v%0d", r), int'(o_rd_v[NR-1-r]), m_rd_v[r]);
        end
        checkOutput("free_v", int'(o_free_v), m_free_v);
        checkOutput("free_a", int'(o_free_a), m_free_a);
        checkOutput("err", int'(o_err), m_err);
    endtask

    // Drive the prepared stimulus for one cycle and check 1 time unit
    // after the edge.
    task automatic step();
        applyStimulus();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear
    // immediately. Release happens on a falling edge.
    task automatic hit_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        idle_inputs();
        applyStimulus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic read0(input int e);
        idle_inputs();
        s_rd_en[0] = 1;
        s_rd_a[0]  = e;
    endtask

    function automatic int rd0();
        return int'(o_rd_c[(NR-1)*CW +: CW]);
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        idle_inputs();
        applyStimulus();
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Post-reset state.
        idle_inputs();
        step();
        checkOutput("post_free_v", int'(o_free_v), 1);
        checkOutput("post_free_a", int'(o_free_a), 0);
        read0(3);
        step();
        checkOutput("post_rd3_c", rd0(), 0);

        // Two incs on entry 1, then one dec.
        idle_inputs();
        s_inc_v[0] = 1; s_inc_a[0] = 1;
        s_inc_v[1] = 1; s_inc_a[1] = 1;
        step();
        read0(1);
        s_dec_v[0] = 1; s_dec_a[0] = 1;
        step();
        checkOutput("two_inc_rd", rd0(), 2);
        read0(1);
        step();
        checkOutput("inc_dec_rd", rd0(), 1);
        checkOutput("inc_dec_v", int'(o_rd_v[NR-1]), 1);

        // Saturation at max, then underflow at 0.
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            s_inc_v[0] = 1; s_inc_a[0] = 2;
            step();
            if (i == 14) checkOutput("sat_no_err", int'(o_err), 0);
        end
        checkOutput("sat_ovf", int'(o_err), ERRON);
        read0(2);
        step();
        checkOutput("sat_rd", rd0(), 15);
        checkOutput("sat_pulse", int'(o_err), 0);
        idle_inputs();
        s_dec_v[0] = 1; s_dec_a[0] = 0;
        step();
        checkOutput("unf_err", int'(o_err), 2 * ERRON);

        // Clear beats inc and dec on the same entry.
        idle_inputs();
        s_inc_v[0] = 1; s_inc_a[0] = 1;
        s_dec_v[0] = 1; s_dec_a[0] = 1;
        s_clr_v[0] = 1; s_clr_a[0] = 1;
        step();
        checkOutput("clr_err", int'(o_err), 0);
        read0(1);
        step();
        checkOutput("clr_rd", rd0(), 0);

        // Free finder ordering.
        idle_inputs();
        s_clr_v[0] = 1; s_clr_a[0] = 2;
        step();
        idle_inputs();
        s_inc_v[0] = 1; s_inc_a[0] = 0;
        s_inc_v[1] = 1; s_inc_a[1] = 1;
        step();
        idle_inputs();
        s_inc_v[0] = 1; s_inc_a[0] = 2;
        step();
        idle_inputs();
        step();
        checkOutput("find_a3", int'(o_free_a), 3);
        s_inc_v[0] = 1; s_inc_a[0] = 3;
        step();
        idle_inputs();
        step();
        checkOutput("find_none", int'(o_free_v), 0);
        s_dec_v[0] = 1; s_dec_a[0] = 1;
        step();
        idle_inputs();
        step();
        checkOutput("find_v1", int'(o_free_v), 1);
        checkOutput("find_a1", int'(o_free_a), 1);

        // Reset while counts are nonzero; every entry reads back 0.
        #2;
        hit_reset();
        for (int e = 0; e < DEPTH; e++) begin
            read0(e);
            step();
            checkOutput("rst_rd", rd0(), 0);
        end

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < NI; p++) begin
                s_inc_v[p] = ($urandom_range(0, 1) == 1);
                s_inc_a[p] = $urandom_range(0, DEPTH - 1);
            end
            for (int p = 0; p < ND; p++) begin
                s_dec_v[p] = ($urandom_range(0, 2) == 0);
                s_dec_a[p] = $urandom_range(0, DEPTH - 1);
            end
            for (int p = 0; p < NC; p++) begin
                s_clr_v[p] = ($urandom_range(0, 9) == 0);
                s_clr_a[p] = $urandom_range(0, DEPTH - 1);
            end
            for (int r = 0; r < NR; r++) begin
                s_rd_en[r] = ($urandom_range(0, 3) != 0);
                s_rd_a[r]  = $urandom_range(0, DEPTH - 1);
            end
            step();
            if (n == 300) begin
                #2;
                hit_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
